// File: rtl/evt_timestamp_unit_pkg.sv
// ============================================================================
// Package  : evt_ts_pkg
// Brief    : FSM encoding, default widths and FIFO entry pack/unpack helpers
// Revision : 1.0
// ============================================================================
`default_nettype none

package evt_ts_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int          C_CNT_W       = 32;
    localparam int          C_ID_W        = 4;
    localparam int          C_DEPTH       = 4;
    localparam int unsigned C_TIMEOUT_CYC = 1000;

    // Entries are handled at a fixed maximum width so one helper serves any CNT_W/ID_W.
    localparam int C_ENT_MAX_W = 80;
    typedef logic [C_ENT_MAX_W-1:0] ent_t;

    function automatic ent_t pack_entry(input logic [63:0] t, input logic [15:0] id,
                                        input int unsigned id_w);
        ent_t mask;
        mask = (ent_t'(1) << id_w) - ent_t'(1);
        return (ent_t'(t) << id_w) | (ent_t'(id) & mask);
    endfunction

    function automatic logic [63:0] entry_time(input ent_t e, input int unsigned id_w);
        return 64'(e >> id_w);
    endfunction

    function automatic logic [15:0] entry_id(input ent_t e, input int unsigned id_w);
        ent_t mask;
        mask = (ent_t'(1) << id_w) - ent_t'(1);
        return 16'(e & mask);
    endfunction

endpackage

`default_nettype wire

// File: rtl/evt_timestamp_unit_if.sv
// ============================================================================
// Interface : evt_timestamp_unit_if
// Brief     : timestamp stream (valid/ready) from the unit to its consumer
// Revision  : 1.0
// ============================================================================
`default_nettype none

interface evt_timestamp_unit_if #(
    parameter int CNT_W = 32,
    parameter int ID_W  = 4
);
    logic             ts_valid;
    logic             ts_ready;
    logic [CNT_W-1:0] ts_time;
    logic [ID_W-1:0]  ts_id;

    modport master (output ts_valid, output ts_time, output ts_id, input ts_ready);
    modport slave  (input ts_valid, input ts_time, input ts_id, output ts_ready);
endinterface

`default_nettype wire

// File: rtl/evt_timestamp_unit_fifo.sv
// ============================================================================
// Module   : sync_fifo_fwft
// Brief    : first-word fall-through FIFO, extra pointer MSB resolves full/empty
// Revision : 1.0
// ============================================================================
`default_nettype none

module sync_fifo_fwft #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             push,
    input  wire logic [WIDTH-1:0] din,
    output logic                  full,
    input  wire logic             pop,
    output logic [WIDTH-1:0]      dout,
    output logic                  empty
);
    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [AW-1:0]    w_wr_idx;
    logic [AW-1:0]    w_rd_idx;

    assign w_wr_idx = r_wr_ptr[AW-1:0];
    assign w_rd_idx = r_rd_ptr[AW-1:0];
    assign empty    = (r_wr_ptr == r_rd_ptr);
    assign full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (w_wr_idx == w_rd_idx);
    assign dout     = r_mem[w_rd_idx];

    // A push while full is only issued alongside a pop, so overwriting the head slot is safe.
    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[w_wr_idx] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end
    end
endmodule

`default_nettype wire

// File: rtl/evt_timestamp_unit.sv
// ============================================================================
// Module   : evt_timestamp_unit
// Brief    : cycle timebase, event-edge timestamp FIFO and sticky timeout
// Revision : 1.0
// ============================================================================
`default_nettype none

module evt_timestamp_unit
    import evt_ts_pkg::*;
#(
    parameter int          CNT_W       = C_CNT_W,
    parameter int          ID_W        = C_ID_W,
    parameter int          DEPTH       = C_DEPTH,
    parameter int unsigned TIMEOUT_CYC = C_TIMEOUT_CYC
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              en,
    input  wire logic              evt,
    input  wire logic [ID_W-1:0]   evt_id,
    evt_timestamp_unit_if.master   ts,
    output logic [CNT_W-1:0]       now,
    output logic                   wrapped,
    output logic [7:0]             drop_cnt,
    output logic                   timeout
);
    localparam int ENT_W = CNT_W + ID_W;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_inc;
    logic [CNT_W-1:0] r_now;
    logic             r_wrapped;
    logic [7:0]       r_drop_cnt;
    logic             r_evt_q;
    logic             r_edge;
    logic [ENT_W-1:0] r_cap;
    logic             w_full;
    logic             w_empty;
    logic             w_valid;
    logic             w_pop;
    logic             w_push;
    logic [ENT_W-1:0] w_dout;

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_inc       = 1'b0;
        case (r_state)
            ST_IDLE: if (en) w_state_nxt = ST_RUN;
            ST_RUN: begin
                if (!en) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_inc = 1'b1;
                    if (r_now == CNT_W'(TIMEOUT_CYC - 1)) w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: w_state_nxt = ST_DONE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_now     <= '0;
            r_wrapped <= 1'b0;
        end else if (w_inc) begin
            r_now <= r_now + CNT_W'(1);
            if (r_now == '1) r_wrapped <= 1'b1;
        end
    end

    // Previous sample resets high so a level held through reset is not an edge.
    // The edge and its {now, id} are registered, then pushed one cycle later.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_evt_q <= 1'b1;
            r_edge  <= 1'b0;
            r_cap   <= '0;
        end else begin
            r_evt_q <= evt;
            r_edge  <= evt & ~r_evt_q;
            r_cap   <= ENT_W'(pack_entry(64'(r_now), 16'(evt_id), ID_W));
        end
    end

    assign w_valid = ~w_empty;
    assign w_pop   = w_valid & ts.ts_ready;
    assign w_push  = r_edge & (~w_full | w_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_drop_cnt <= '0;
        end else if (r_edge && w_full && !w_pop && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    sync_fifo_fwft #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .din   (r_cap),
        .full  (w_full),
        .pop   (w_pop),
        .dout  (w_dout),
        .empty (w_empty)
    );

    assign ts.ts_valid = w_valid;
    assign ts.ts_time  = w_valid ? CNT_W'(entry_time(ent_t'(w_dout), ID_W)) : '0;
    assign ts.ts_id    = w_valid ? ID_W'(entry_id(ent_t'(w_dout), ID_W)) : '0;
    assign now         = r_now;
    assign wrapped     = r_wrapped;
    assign drop_cnt    = r_drop_cnt;
    assign timeout     = (r_state == ST_DONE);
endmodule

`default_nettype wire
